sc1602_scheduler: RTL

Sits between user logic and the SC1602 4-bit LCD driver, in the sys_clk domain. Holds a LINE_LEN-character display buffer and feeds it to the driver one character per drawing cycle. Arbitrates the driver's command input between an external command requester and an internal periodic auto-scroll timer. Replaces ad-hoc edge-clocked character counters with fully synchronous sequencing.

---
 rtl/sc1602_pkg.sv | 13 +
 rtl/sc1602_sync2.sv | 24 ++
 rtl/sc1602_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sc1602_pkg.sv
// Shared command codes, character constants and scheduler state type
// for the SC1602 LCD scheduler.
package sc1602_pkg;

  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_SHIFT_L = 3'b010;
  localparam logic [2:0] CMD_SHIFT_R = 3'b011;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;

  typedef enum logic {IDLE, ISSUE} sched_state_t;

endpackage

// File: rtl/sc1602_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sc1602_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sc1602_scheduler.sv
// Character buffer, auto-scroll timer and command arbiter feeding the
// SC1602 4-bit LCD driver; fully synchronous to sys_clk.
module sc1602_scheduler
  import sc1602_pkg::*;
#(
  parameter int unsigned LINE_LEN     = 16,
  parameter int unsigned SHIFT_PERIOD = 13_500_000,
  parameter int unsigned ACK_TIMEOUT  = 1024
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        wr_en,
  input  logic [$clog2(LINE_LEN)-1:0] wr_addr,
  input  logic [7:0]                  wr_data,
  input  logic                        cmd_valid,
  input  logic [2:0]                  cmd,
  output logic                        cmd_ready,
  input  logic                        scroll_en,
  input  logic                        drv_ready,
  input  logic                        drv_drawing,
  output logic [7:0]                  drv_character,
  output logic [2:0]                  drv_command,
  output logic                        frame_done,
  output logic                        cmd_err
);

  localparam int unsigned AW  = $clog2(LINE_LEN);
  localparam int unsigned TW  = (SHIFT_PERIOD > 1) ? $clog2(SHIFT_PERIOD) : 1;
  localparam int unsigned TOW = (ACK_TIMEOUT > 1)  ? $clog2(ACK_TIMEOUT)  : 1;

  logic w_rdy_s;
  logic w_drw_s;
  logic w_fall;
  logic w_tick;
  logic w_accept;
  logic w_scroll_take;

  logic [7:0]     r_buf [LINE_LEN];
  logic [AW-1:0]  r_idx;
  logic           r_drw_d;
  logic           r_frame_done;
  logic [7:0]     r_char;
  logic [TW-1:0]  r_timer;
  logic           r_scroll_pending;
  sched_state_t   r_state;
  logic [2:0]     r_drv_command;
  logic           r_cmd_err;
  logic [TOW-1:0] r_to_cnt;

  sc1602_sync2 u_sync_rdy (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (drv_ready),
    .q   (w_rdy_s)
  );

  sc1602_sync2 u_sync_drw (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (drv_drawing),
    .q   (w_drw_s)
  );

  // Edge detector is built from two registers, so the pulse is glitch-free.
  assign w_fall = r_drw_d & ~w_drw_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < LINE_LEN; i++) r_buf[i] <= CHAR_SPACE;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_drw_d      <= 1'b0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_char       <= CHAR_SPACE;
    end else begin
      r_drw_d      <= w_drw_s;
      r_frame_done <= w_fall && (r_idx == AW'(LINE_LEN - 1));
      if (w_fall) r_idx <= r_idx + AW'(1);
      // Bypass so a write to the slot being read shows up next cycle.
      r_char <= (wr_en && (wr_addr == r_idx)) ? wr_data : r_buf[r_idx];
    end
  end

  assign w_tick = (r_timer == TW'(SHIFT_PERIOD - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_timer          <= '0;
      r_scroll_pending <= 1'b0;
    end else begin
      r_timer <= w_tick ? '0 : r_timer + TW'(1);
      if (!scroll_en)         r_scroll_pending <= 1'b0;
      else if (w_tick)        r_scroll_pending <= 1'b1;
      else if (w_scroll_take) r_scroll_pending <= 1'b0;
    end
  end

  assign w_accept      = (r_state == IDLE) & cmd_valid & w_rdy_s;
  assign w_scroll_take = (r_state == IDLE) & ~cmd_valid & r_scroll_pending & w_rdy_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_drv_command <= CMD_NOP;
      r_cmd_err     <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_cmd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_accept) begin
            if (cmd != CMD_NOP) begin
              r_drv_command <= cmd;
              r_state       <= ISSUE;
            end
          end else if (w_scroll_take) begin
            r_drv_command <= CMD_SHIFT_L;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!w_rdy_s) begin
            r_drv_command <= CMD_NOP;
            r_state       <= IDLE;
          end else if (r_to_cnt == TOW'(ACK_TIMEOUT - 1)) begin
            r_drv_command <= CMD_NOP;
            r_cmd_err     <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TOW'(1);
          end
        end
        default: begin
          r_drv_command <= CMD_NOP;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = (r_state == IDLE) & w_rdy_s;
  assign drv_character = r_char;
  assign drv_command   = r_drv_command;
  assign frame_done    = r_frame_done;
  assign cmd_err       = r_cmd_err;

endmodule
